// File: rtl/dnn_op_sequencer_pkg.sv
// ============================================================================
// Module   : dnn_op_sequencer_pkg
// Purpose  : Opcode values, size-field layout, FSM encodings and op length
//            helper shared by the op sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dnn_op_sequencer_pkg;

    localparam int c_LEN_W = 14;

    localparam logic [3:0] c_OP_IDLE   = 4'd0;
    localparam logic [3:0] c_OP_MULT   = 4'd1;
    localparam logic [3:0] c_OP_SWRITE = 4'd2;
    localparam logic [3:0] c_OP_SREAD  = 4'd3;

    localparam int c_SIZE_LINE_MSB = 8;
    localparam int c_SIZE_LINE_LSB = 6;
    localparam int c_SIZE_CELL_MSB = 5;
    localparam int c_SIZE_CELL_LSB = 0;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    // Cycles an op must be held on the controller; 14 bits covers 64*8*8+DRAIN.
    function automatic logic [c_LEN_W-1:0] op_len(
        input logic [3:0]         opcode,
        input logic [8:0]         size,
        input logic [c_LEN_W-1:0] drain,
        input logic [c_LEN_W-1:0] lanes
    );
        logic [c_LEN_W-1:0] cells;
        logic [c_LEN_W-1:0] lines;
        cells = c_LEN_W'(size[c_SIZE_CELL_MSB:c_SIZE_CELL_LSB]) + c_LEN_W'(1);
        lines = c_LEN_W'(size[c_SIZE_LINE_MSB:c_SIZE_LINE_LSB]) + c_LEN_W'(1);
        if (opcode == c_OP_MULT) begin
            op_len = cells * lines * lines + drain;
        end else begin
            op_len = cells * lines * lanes;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/dnn_op_sequencer_cmd_fifo.sv
// ============================================================================
// Module   : dnn_op_sequencer_cmd_fifo
// Purpose  : DEPTH x WIDTH synchronous command FIFO, async reset, no
//            write-to-read pass-through.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dnn_op_sequencer_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = (c_AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_rdata = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/dnn_op_sequencer.sv
// ============================================================================
// Module   : dnn_op_sequencer
// Purpose  : Queues host op words and holds each on the matrix controller for
//            its full length, with idle gaps and serial write/read handshakes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dnn_op_sequencer
    import dnn_op_sequencer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int LANES  = 8,
    parameter int DRAIN  = 24,
    parameter int GAP    = 1,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_op,
    input  logic [8:0]  cfg_size,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [31:0] ctrl_operation,
    output logic        ctrl_enable,
    output logic [31:0] ctrl_in_data,
    output logic [8:0]  ctrl_size,
    input  logic [31:0] ctrl_out_data,
    output logic        busy,
    output logic        err_opcode
);

    localparam logic [c_LEN_W-1:0] c_DRAIN    = c_LEN_W'(DRAIN);
    localparam logic [c_LEN_W-1:0] c_LANES    = c_LEN_W'(LANES);
    localparam logic [c_LEN_W-1:0] c_GAP_LAST = c_LEN_W'(GAP - 1);
    localparam logic [c_LEN_W-1:0] c_CNT_ONE  = c_LEN_W'(1);

    logic [1:0]         r_state,  w_state_nxt;
    logic [31:0]        r_op,     w_op_nxt;
    logic [3:0]         r_opcode, w_opcode_nxt;
    logic [8:0]         r_size,   w_size_nxt;
    logic [c_LEN_W-1:0] r_cnt,    w_cnt_nxt;
    logic               r_err,    w_err_nxt;
    logic               r_live;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [31:0]        w_fifo_data;
    logic [3:0]         w_pop_opcode;
    logic [c_LEN_W-1:0] w_len;
    logic               w_swrite;
    logic               w_counted;
    logic               w_rd_issue;

    dnn_op_sequencer_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (cmd_op),
        .o_rdata (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_push       = cmd_valid && cmd_ready;
    assign w_pop_opcode = w_fifo_data[3:0];
    assign w_len        = op_len(w_pop_opcode, cfg_size, c_DRAIN, c_LANES);
    assign w_swrite     = (r_state == c_ST_ISSUE) && (r_opcode == c_OP_SWRITE);
    assign w_counted    = !w_swrite || wr_valid;
    assign w_rd_issue   = (r_state == c_ST_ISSUE) && (r_opcode == c_OP_SREAD);

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_opcode_nxt = r_opcode;
        w_size_nxt   = r_size;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_pop_opcode > c_OP_SREAD) begin
                        w_err_nxt = 1'b1;
                    end else if (w_pop_opcode != c_OP_IDLE) begin
                        w_op_nxt     = w_fifo_data;
                        w_opcode_nxt = w_pop_opcode;
                        w_size_nxt   = cfg_size;
                        w_cnt_nxt    = w_len - c_CNT_ONE;
                        w_state_nxt  = c_ST_ISSUE;
                    end
                end
            end
            c_ST_ISSUE: begin
                if (w_counted) begin
                    if (r_cnt == '0) begin
                        w_op_nxt    = '0;
                        w_cnt_nxt   = c_GAP_LAST;
                        w_state_nxt = c_ST_GAP;
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                    end
                end
            end
            c_ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_op_nxt    = '0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_op     <= '0;
            r_opcode <= c_OP_IDLE;
            r_size   <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_live   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_opcode <= w_opcode_nxt;
            r_size   <= w_size_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            r_live   <= 1'b1;
        end
    end

    // r_live keeps enable/ready low until the first edge after reset release.
    assign cmd_ready      = r_live && !w_full;
    assign wr_ready       = w_swrite;
    assign ctrl_enable    = r_live && !(w_swrite && !wr_valid);
    assign ctrl_operation = r_op;
    assign ctrl_size      = r_size;
    assign ctrl_in_data   = wr_data;
    assign rd_data        = ctrl_out_data;
    assign busy           = !w_empty || (r_state != c_ST_IDLE);
    assign err_opcode     = r_err;

    generate
        if (RD_LAT == 0) begin : g_rd_direct
            assign rd_valid = w_rd_issue;
        end else begin : g_rd_pipe
            logic [RD_LAT-1:0] r_rd_sr;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_rd_sr <= '0;
                end else begin
                    r_rd_sr <= (r_rd_sr << 1) | RD_LAT'(w_rd_issue);
                end
            end
            assign rd_valid = r_rd_sr[RD_LAT-1];
        end
    endgenerate

endmodule

`default_nettype wire
